// File: rtl/gpu_sched_pkg.sv
// Shared types for the draw scheduler: opcode values, FSM states and the
// instruction record that travels from the decoder through the FIFO to the
// raster engine.
package gpu_sched_pkg;

  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int CHANNEL_BITS = 8;

  localparam logic [3:0] OP_LINE   = 4'b0100;
  localparam logic [3:0] OP_RECT   = 4'b0101;
  localparam logic [3:0] OP_CIRCLE = 4'b0110;
  localparam logic [3:0] OP_ARC    = 4'b0111;
  localparam logic [3:0] OP_CLEAR  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]              opcode;
    logic [WIDTH_BITS-1:0]   x1;
    logic [HEIGHT_BITS-1:0]  y1;
    logic [WIDTH_BITS-1:0]   x2;
    logic [HEIGHT_BITS-1:0]  y2;
    logic [WIDTH_BITS-1:0]   rad;
    logic [2:0]              oct;
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
  } instr_t;

  // The engine only understands the contiguous opcode range line..clear.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op >= OP_LINE) && (op <= OP_CLEAR);
  endfunction

endpackage

// File: rtl/gpu_instr_fifo.sv
// Small show-ahead FIFO of draw instructions. A push into a full FIFO is
// still taken when the head is popped in the same cycle; flush discards
// everything, including a push or pop in that cycle.
module gpu_instr_fifo
  import gpu_sched_pkg::*;
#(
  parameter type T     = instr_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  T     din_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];

  // Storage, pointers (wrapping naturally at DEPTH) and occupancy count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gpu_draw_scheduler.sv
// Queues decoded draw instructions and hands them to the raster engine one at
// a time over a start/done handshake, with a watchdog and sticky host flags.
module gpu_draw_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    push_i,
  input  logic [3:0]              opcode_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic [WIDTH_BITS-1:0]   rad_i,
  input  logic [2:0]              oct_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic                    flush_i,
  input  logic                    clr_status_i,
  input  logic                    done_i,
  output logic                    start_o,
  output logic [3:0]              opcode_o,
  output logic [WIDTH_BITS-1:0]   x1_o,
  output logic [HEIGHT_BITS-1:0]  y1_o,
  output logic [WIDTH_BITS-1:0]   x2_o,
  output logic [HEIGHT_BITS-1:0]  y2_o,
  output logic [WIDTH_BITS-1:0]   rad_o,
  output logic [2:0]              oct_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic                    busy_o,
  output logic                    idle_o,
  output logic                    full_o,
  output logic                    overflow_o,
  output logic                    bad_op_o,
  output logic                    timeout_o
);

  localparam int WD_BITS = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e             state_q;
  instr_t             instr_q;
  instr_t             push_instr;
  instr_t             head;
  logic               start_q;
  logic [WD_BITS-1:0] wdog_q;
  logic               overflow_q, overflow_d;
  logic               bad_op_q, bad_op_d;
  logic               timeout_q, timeout_d;
  logic               fifo_full, fifo_empty;
  logic               pop;
  logic               wdog_expired;

  assign push_instr = '{opcode: opcode_i, x1: x1_i, y1: y1_i, x2: x2_i, y2: y2_i,
                        rad: rad_i, oct: oct_i, r: r_i, g: g_i, b: b_i};

  gpu_instr_fifo #(
    .T     (instr_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (push_i),
    .pop_i   (pop),
    .flush_i (flush_i),
    .din_i   (push_instr),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Only IDLE consumes the FIFO head; a flush in the same cycle discards it instead.
  assign pop = (state_q == ST_IDLE) && !fifo_empty && !flush_i;

  // The counter holds cycles spent in WAIT; the last allowed cycle aborts unless done arrives.
  assign wdog_expired = (TIMEOUT_CYC != 0) && (state_q == ST_WAIT) && !done_i &&
                        (wdog_q == WD_BITS'(TIMEOUT_CYC - 1));

  // Sticky flags: a new event in the clearing cycle keeps the flag set.
  assign overflow_d = (push_i && !flush_i && fifo_full && !pop) || (overflow_q && !clr_status_i);
  assign bad_op_d   = (pop && !is_legal_op(head.opcode)) || (bad_op_q && !clr_status_i);
  assign timeout_d  = wdog_expired || (timeout_q && !clr_status_i);

  // Dispatch FSM with the registered start strobe, instruction fields and watchdog.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      start_q <= 1'b0;
      wdog_q  <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop && is_legal_op(head.opcode)) begin
            instr_q <= head;
            start_q <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wdog_q  <= '0;
          state_q <= done_i ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (done_i || wdog_expired) state_q <= ST_IDLE;
          else                        wdog_q  <= wdog_q + WD_BITS'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Host-visible sticky status registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_q <= 1'b0;
      bad_op_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      bad_op_q   <= bad_op_d;
      timeout_q  <= timeout_d;
    end
  end

  assign start_o    = start_q;
  assign opcode_o   = instr_q.opcode;
  assign x1_o       = instr_q.x1;
  assign y1_o       = instr_q.y1;
  assign x2_o       = instr_q.x2;
  assign y2_o       = instr_q.y2;
  assign rad_o      = instr_q.rad;
  assign oct_o      = instr_q.oct;
  assign r_o        = instr_q.r;
  assign g_o        = instr_q.g;
  assign b_o        = instr_q.b;
  assign busy_o     = (state_q != ST_IDLE);
  assign idle_o     = fifo_empty && (state_q == ST_IDLE);
  assign full_o     = fifo_full;
  assign overflow_o = overflow_q;
  assign bad_op_o   = bad_op_q;
  assign timeout_o  = timeout_q;

endmodule
